key_pulse_gen: RTL and testbench

Conditions the raw time-set push-buttons of the digital clock and produces the clean set strobes that feed the seconds, minutes and hours advance inputs in set mode. Each key gets:
- a two-flop synchronizer;
- a counter-based debouncer;
- a rising-edge one-shot;
- an optional hold-to-auto-repeat generator.

Keys are processed independently and in parallel; all outputs are registered in the `clk` domain.

---
 rtl/key_pulse_gen_if.sv | 11 +
 rtl/key_pulse_gen.sv | 87 ++++++++
 tb/tb_key_pulse_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: raw key inputs and conditioned key outputs of key_pulse_gen.
interface key_pulse_gen_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_pulse;
  logic [N_KEYS-1:0] key_repeating;
  modport master (output key_in, input key_level, key_pulse, key_repeating);
  modport slave (input key_in, output key_level, key_pulse, key_repeating);
endinterface

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: per-key synchronizer, debouncer and one-shot set strobes.
// Define KEY_PULSE_AUTOREPEAT_EN to add hold-to-auto-repeat (DELAY/REPEAT states).
module key_pulse_gen #(
  parameter int N_KEYS           = 3,
  parameter int DEBOUNCE_CYC     = 1000000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000
) (
  input logic            clk,
  input logic            reset,
  key_pulse_gen_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
`ifdef KEY_PULSE_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY_CYC > REPEAT_RATE_CYC ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif
  logic [N_KEYS-1:0] level, pulse, repeating;
  if (DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 2 || REPEAT_RATE_CYC < 2) begin : g_bad_params
    $error("key_pulse_gen: all cycle parameters must be >= 2");
  end
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic          lvl, lvl_q, pulse_q, rep_q;
    state_t        state;
`ifdef KEY_PULSE_AUTOREPEAT_EN
    logic [HW-1:0] hold_cnt;
`endif
    // lvl is the raw debounced state; lvl_q and the FSM outputs trail it by one
    // register so key_level and the first key_pulse rise on the same edge.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync    <= '0;
        db_cnt  <= '0;
        lvl     <= 1'b0;
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
        rep_q   <= 1'b0;
        state   <= IDLE;
`ifdef KEY_PULSE_AUTOREPEAT_EN
        hold_cnt <= '0;
`endif
      end else begin
        sync    <= {sync[0], bus.key_in[k]};
        lvl_q   <= lvl;
        pulse_q <= 1'b0;
        if (sync[1] == lvl) db_cnt <= '0;
        else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
          lvl    <= ~lvl;
          db_cnt <= '0;
        end else db_cnt <= db_cnt + 1'b1;
`ifdef KEY_PULSE_AUTOREPEAT_EN
        if (!lvl) begin
          state    <= IDLE;
          hold_cnt <= '0;
          rep_q    <= 1'b0;
        end else if (state == IDLE) begin
          pulse_q  <= 1'b1;
          hold_cnt <= '0;
          state    <= DELAY;
        end else if (hold_cnt == HW'((state == DELAY ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC) - 1)) begin
          pulse_q  <= 1'b1;
          hold_cnt <= '0;
          state    <= REPEAT;
          rep_q    <= 1'b1;
        end else hold_cnt <= hold_cnt + 1'b1;
`else
        rep_q <= 1'b0;
        if (!lvl) state <= IDLE;
        else if (state == IDLE) begin
          pulse_q <= 1'b1;
          state   <= HELD;
        end
`endif
      end
    end
    assign level[k]     = lvl_q;
    assign pulse[k]     = pulse_q;
    assign repeating[k] = rep_q;
  end
  assign bus.key_level     = level;
  assign bus.key_pulse     = pulse;
  assign bus.key_repeating = repeating;
endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed scoreboard bench for key_pulse_gen (DEBOUNCE 4, DELAY 20, RATE 8).
module tb_key_pulse_gen;
`ifdef KEY_PULSE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int LAT = 7;
  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic [2:0] rep;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  key_pulse_gen_if #(.N_KEYS(3)) bus ();
  key_pulse_gen #(
    .N_KEYS(3),
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_RATE_CYC(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic push(input int c, input logic [2:0] p, input logic [2:0] r);
    exp_t e;
    e.cyc = c;
    e.pulse = p;
    e.rep = r;
    q.push_back(e);
  endtask
  // Scoreboard: every strobe must match the next expected one; overdue entries are misses.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.key_pulse !== 3'b000) begin
      if (q.size() == 0) chk("unexpected_pulse", {29'd0, bus.key_pulse}, 32'd0);
      else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_bits", {29'd0, bus.key_pulse}, {29'd0, e.pulse});
        chk("pulse_repeating", {29'd0, bus.key_repeating}, {29'd0, e.rep});
      end
    end else if (q.size() > 0 && cyc > q[0].cyc) begin
      e = q.pop_front();
      chk("missed_pulse", cyc, e.cyc);
    end
  end
  initial begin
    int c, p, r;
    reset = 1'b0;
    bus.key_in = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_level", {29'd0, bus.key_level}, 32'd0);
    chk("rst_pulse", {29'd0, bus.key_pulse}, 32'd0);
    chk("rst_repeating", {29'd0, bus.key_repeating}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    // 1: clean press on key 0
    c = cyc;
    bus.key_in[0] = 1'b1;
    push(c + LAT, 3'b001, 3'b000);
    wait_to(c + LAT - 1);
    chk("t1_level_before", {29'd0, bus.key_level}, 32'd0);
    wait_to(c + LAT);
    chk("t1_level_rise", {29'd0, bus.key_level}, 32'd1);
    wait_to(c + 10);
    bus.key_in[0] = 1'b0;
    wait_to(c + 10 + LAT - 1);
    chk("t1_level_held", {29'd0, bus.key_level}, 32'd1);
    wait_to(c + 10 + LAT);
    chk("t1_level_fall", {29'd0, bus.key_level}, 32'd0);
    wait_to(c + 24);
    // 2: bouncing press on key 1
    c = cyc;
    bus.key_in[1] = 1'b1;
    wait_to(c + 2);
    bus.key_in[1] = 1'b0;
    wait_to(c + 4);
    bus.key_in[1] = 1'b1;
    wait_to(c + 6);
    bus.key_in[1] = 1'b0;
    wait_to(c + 8);
    bus.key_in[1] = 1'b1;
    push(c + 8 + LAT, 3'b010, 3'b000);
    wait_to(c + 8 + LAT - 1);
    chk("t2_level_during_bounce", {29'd0, bus.key_level}, 32'd0);
    wait_to(c + 8 + LAT);
    chk("t2_level_rise", {29'd0, bus.key_level}, 32'd2);
    wait_to(c + 20);
    bus.key_in[1] = 1'b0;
    wait_to(c + 34);
    chk("t2_level_released", {29'd0, bus.key_level}, 32'd0);
    // 3/4: hold key 2, then release exactly on a repeat expiry
    c = cyc;
    p = c + LAT;
    bus.key_in[2] = 1'b1;
    push(p, 3'b100, 3'b000);
    if (AR) begin
      push(p + 20, 3'b100, 3'b100);
      for (int n = 1; n <= 4; n++) push(p + 20 + 8 * n, 3'b100, 3'b100);
    end
    wait_to(p + 19);
    chk("t3_rep_before_delay", {31'd0, bus.key_repeating[2]}, 32'd0);
    wait_to(p + 20);
    chk("t3_rep_after_delay", {31'd0, bus.key_repeating[2]}, {31'd0, AR});
    wait_to(p + 53);
    bus.key_in[2] = 1'b0;
    wait_to(p + 59);
    chk("t4_level_before_release", {29'd0, bus.key_level}, 32'd4);
    chk("t4_rep_before_release", {31'd0, bus.key_repeating[2]}, {31'd0, AR});
    wait_to(p + 60);
    chk("t4_level_released", {29'd0, bus.key_level}, 32'd0);
    chk("t4_rep_released", {29'd0, bus.key_repeating}, 32'd0);
    chk("t4_no_pulse_on_expiry", {29'd0, bus.key_pulse}, 32'd0);
    wait_to(p + 70);
    // 5: keys 0 and 1 together
    c = cyc;
    bus.key_in[1:0] = 2'b11;
    push(c + LAT, 3'b011, 3'b000);
    wait_to(c + LAT);
    chk("t5_level_both", {29'd0, bus.key_level}, 32'd3);
    wait_to(c + 10);
    bus.key_in[1:0] = 2'b00;
    wait_to(c + 24);
    // 6: reset during REPEAT with key 2 held
    c = cyc;
    p = c + LAT;
    bus.key_in[2] = 1'b1;
    push(p, 3'b100, 3'b000);
    if (AR) push(p + 20, 3'b100, 3'b100);
    wait_to(p + 25);
    chk("t6_rep_before_reset", {31'd0, bus.key_repeating[2]}, {31'd0, AR});
    reset = 1'b0;
    #1;
    chk("t6_rst_level", {29'd0, bus.key_level}, 32'd0);
    chk("t6_rst_pulse", {29'd0, bus.key_pulse}, 32'd0);
    chk("t6_rst_repeating", {29'd0, bus.key_repeating}, 32'd0);
    wait_to(p + 28);
    chk("t6_rst_level_held", {29'd0, bus.key_level}, 32'd0);
    r = cyc;
    reset = 1'b1;
    push(r + LAT, 3'b100, 3'b000);
    if (AR) begin
      push(r + LAT + 20, 3'b100, 3'b100);
      push(r + LAT + 28, 3'b100, 3'b100);
    end
    wait_to(r + LAT - 1);
    chk("t6_level_redebounce", {29'd0, bus.key_level}, 32'd0);
    wait_to(r + LAT);
    chk("t6_level_after_reset", {29'd0, bus.key_level}, 32'd4);
    wait_to(r + 36);
    bus.key_in[2] = 1'b0;
    wait_to(r + 50);
    chk("t6_level_final", {29'd0, bus.key_level}, 32'd0);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
